// File: rtl/apg_pkg.sv
// Shared defaults and types for the APG run-length expander.
// Imported by the interface, entry FIFO and expander top.
package apg_pkg;

    localparam int APG_NUM_SIG  = 8;
    localparam int APG_NUM_SAMP = 128;
    localparam int APG_CNT_W    = 16;

    typedef struct packed {
        logic [APG_NUM_SIG-1:0] value;
        logic [APG_CNT_W-1:0]   count;
    } rle_entry_t;

    typedef enum logic [0:0] {
        RLE_IDLE   = 1'b0,
        RLE_EXPAND = 1'b1
    } apg_rle_state_t;

endpackage

// File: rtl/apg_rle_expander_if.sv
// Entry push bus and expanded pattern-word write channel.
// The master pushes entries and watches the generator writes.
interface apg_rle_expander_if
    import apg_pkg::*;
#(
    parameter int NUM_SIG = APG_NUM_SIG,
    parameter int CNT_W   = APG_CNT_W
) ();

    logic [NUM_SIG-1:0] entry_value;
    logic [CNT_W-1:0]   entry_count;
    logic               entry_wrStrobe;
    logic [NUM_SIG-1:0] write_channel;
    logic               write_channel_wrStrobe;

    modport master (
        output entry_value,
        output entry_count,
        output entry_wrStrobe,
        input  write_channel,
        input  write_channel_wrStrobe
    );

    modport slave (
        input  entry_value,
        input  entry_count,
        input  entry_wrStrobe,
        output write_channel,
        output write_channel_wrStrobe
    );

endinterface

// File: rtl/apg_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush.
// A write into a full FIFO lands only when a read frees a slot.
module apg_sync_fifo
    import apg_pkg::*;
#(
    parameter int WIDTH = APG_NUM_SIG + APG_CNT_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush && !rst) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/apg_rle_expander.sv
// Run-length expander feeding the arbitrary pattern generator.
// Expands FIFO'd (value, count) entries into one word per strobe.
module apg_rle_expander
    import apg_pkg::*;
#(
    parameter int NUM_SIG    = APG_NUM_SIG,
    parameter int NUM_SAMP   = APG_NUM_SAMP,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = APG_CNT_W
) (
    input  logic                axi_clk,
    input  logic                axi_reset,
    input  logic                clear,
    apg_rle_expander_if.slave   bus,
    output logic [31:0]         n_samples,
    output logic                fifo_full,
    output logic                busy,
    output logic                overflow,
    output logic                truncated
);

    typedef struct packed {
        logic [NUM_SIG-1:0] value;
        logic [CNT_W-1:0]   count;
    } entry_t;

    apg_rle_state_t     state;
    logic [NUM_SIG-1:0] cur_value;
    logic [CNT_W-1:0]   remaining;
    entry_t             push_ent;
    entry_t             head;
    logic               empty;
    logic               pop;
    logic               capped;
    logic               cap_word;
    logic               last_word;

    assign push_ent  = {bus.entry_value, bus.entry_count};
    assign capped    = (n_samples >= 32'(NUM_SAMP));
    assign cap_word  = (n_samples == 32'(NUM_SAMP - 1));
    assign last_word = (remaining == CNT_W'(1));

    // IDLE pops to load or, once capped, to drain one entry per cycle
    assign pop  = !empty &&
                  ((state == RLE_IDLE) || (last_word && !cap_word));
    assign busy = !empty || (state == RLE_EXPAND);

    apg_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axi_clk),
        .rst     (axi_reset),
        .flush   (clear),
        .wr_en   (bus.entry_wrStrobe),
        .wr_data (push_ent),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (empty)
    );

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state                      <= RLE_IDLE;
            cur_value                  <= '0;
            remaining                  <= '0;
            n_samples                  <= '0;
            overflow                   <= 1'b0;
            truncated                  <= 1'b0;
            bus.write_channel          <= '0;
            bus.write_channel_wrStrobe <= 1'b0;
        end else if (clear) begin
            state                      <= RLE_IDLE;
            remaining                  <= '0;
            n_samples                  <= '0;
            overflow                   <= 1'b0;
            truncated                  <= 1'b0;
            bus.write_channel_wrStrobe <= 1'b0;
        end else begin
            bus.write_channel_wrStrobe <= 1'b0;
            if (bus.entry_wrStrobe && fifo_full && !pop)
                overflow <= 1'b1;
            unique case (state)
                RLE_IDLE: begin
                    if (!empty) begin
                        if (capped) begin
                            truncated <= 1'b1;
                        end else if (head.count != '0) begin
                            cur_value <= head.value;
                            remaining <= head.count;
                            state     <= RLE_EXPAND;
                        end
                    end
                end
                RLE_EXPAND: begin
                    bus.write_channel          <= cur_value;
                    bus.write_channel_wrStrobe <= 1'b1;
                    n_samples                  <= n_samples + 32'd1;
                    remaining                  <= remaining - 1'b1;
                    if (cap_word) begin
                        state <= RLE_IDLE;
                        if (!last_word || !empty) truncated <= 1'b1;
                    end else if (last_word) begin
                        if (!empty && head.count != '0) begin
                            cur_value <= head.value;
                            remaining <= head.count;
                        end else begin
                            state <= RLE_IDLE;
                        end
                    end
                end
                default: state <= RLE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apg_rle_expander.sv
// Self-checking bench for apg_rle_expander.
module tb_apg_rle_expander;
    import apg_pkg::*;

    localparam int NSAMP = 128;
    localparam int DEPTH = 16;

    logic        axi_clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] n_samples;
    logic        fifo_full;
    logic        busy;
    logic        overflow;
    logic        truncated;

    apg_rle_expander_if #(.NUM_SIG(8), .CNT_W(16)) bus ();

    apg_rle_expander #(
        .NUM_SIG    (8),
        .NUM_SAMP   (NSAMP),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (16)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_reset (axi_reset),
        .clear     (clear),
        .bus       (bus.slave),
        .n_samples (n_samples),
        .fifo_full (fifo_full),
        .busy      (busy),
        .overflow  (overflow),
        .truncated (truncated)
    );

    always #5 axi_clk = ~axi_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] got_v[$];
    int         got_c[$];
    logic [7:0] exp_q[$];
    int         m_total;
    logic       m_trunc;

    typedef struct {
        logic [7:0] value;
        int         count;
        int         exp_n;
        logic       exp_trunc;
    } vec_t;
    vec_t vecs[6];

    always @(posedge axi_clk) cyc <= cyc + 1;

    always @(negedge axi_clk) begin
        if (!axi_reset && bus.write_channel_wrStrobe) begin
            got_v.push_back(bus.write_channel);
            got_c.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge axi_clk);
        #1;
    endtask

    task automatic flush_log();
        got_v.delete();
        got_c.delete();
    endtask

    task automatic push(input logic [7:0] v, input int c);
        bus.entry_value    = v;
        bus.entry_count    = 16'(c);
        bus.entry_wrStrobe = 1'b1;
        tick();
        bus.entry_wrStrobe = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush_log();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || bus.write_channel_wrStrobe) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(busy | bus.write_channel_wrStrobe), 32'd0);
    endtask

    task automatic wait_words(input string name, input int want,
                              input int budget);
        int n = 0;
        while (got_v.size() < want && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(got_v.size()), 32'(want));
    endtask

    // Reference: words an entry contributes given the cap, in push order
    task automatic model_push(input logic [7:0] v, input int c);
        int room = NSAMP - m_total;
        if (m_total >= NSAMP) begin
            m_trunc = 1'b1;
        end else begin
            if (c > room) m_trunc = 1'b1;
            for (int k = 0; k < c && k < room; k++) exp_q.push_back(v);
            m_total += (c < room) ? c : room;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_total = 0;
        m_trunc = 1'b0;
    endtask

    task automatic cmp_stream(input string name);
        check({name, "_len"}, 32'(got_v.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_v.size(); i++)
            check($sformatf("%s_w%0d", name, i), 32'(got_v[i]),
                  32'(exp_q[i]));
    endtask

    initial begin
        int e;
        int w;
        logic [7:0] rv;
        int rc;
        int maxc[3];
        vecs[0] = '{8'h5A, 1, 1, 1'b0};
        vecs[1] = '{8'h3C, 0, 0, 1'b0};
        vecs[2] = '{8'hFF, 5, 5, 1'b0};
        vecs[3] = '{8'h81, 128, 128, 1'b0};
        vecs[4] = '{8'h42, 200, 128, 1'b1};
        vecs[5] = '{8'h00, 3, 3, 1'b0};
        maxc[0] = 3;
        maxc[1] = 7;
        maxc[2] = 12;
        bus.entry_value    = '0;
        bus.entry_count    = '0;
        bus.entry_wrStrobe = 1'b0;

        repeat (3) tick();
        axi_reset = 1'b0;
        tick();
        check("rst_wc", 32'(bus.write_channel), 32'd0);
        check("rst_strobe", 32'(bus.write_channel_wrStrobe), 32'd0);
        check("rst_nsamp", n_samples, 32'd0);
        check("rst_flags", {28'd0, fifo_full, busy, overflow, truncated},
              32'd0);

        // back-to-back single-word entries and push-to-write latency
        flush_log();
        e = cyc + 1;
        for (int i = 0; i < 6; i++) push(8'((2 << i) - 1), 1);
        wait_idle("t1_idle", 50);
        check("t1_len", 32'(got_v.size()), 32'd6);
        if (got_c.size() > 0) check("t1_lat", 32'(got_c[0] - e), 32'd2);
        for (int i = 0; i < got_v.size() && i < 6; i++) begin
            check($sformatf("t1_w%0d", i), 32'(got_v[i]),
                  32'((2 << i) - 1));
            check($sformatf("t1_c%0d", i), 32'(got_c[i] - got_c[0]),
                  32'(i));
        end
        check("t1_nsamp", n_samples, 32'd6);

        // zero-count entry in the middle
        do_clear();
        model_reset();
        push(8'hAA, 3);
        push(8'h55, 0);
        push(8'h0F, 2);
        model_push(8'hAA, 3);
        model_push(8'h55, 0);
        model_push(8'h0F, 2);
        wait_idle("t2_idle", 50);
        cmp_stream("t2");
        check("t2_nsamp", n_samples, 32'd5);

        // single-entry table
        for (int i = 0; i < 6; i++) begin
            do_clear();
            push(vecs[i].value, vecs[i].count);
            wait_idle($sformatf("tab%0d_idle", i), 400);
            check($sformatf("tab%0d_n", i), 32'(got_v.size()),
                  32'(vecs[i].exp_n));
            check($sformatf("tab%0d_nsamp", i), n_samples,
                  32'(vecs[i].exp_n));
            check($sformatf("tab%0d_trunc", i), 32'(truncated),
                  32'(vecs[i].exp_trunc));
            w = 0;
            foreach (got_v[k]) if (got_v[k] !== vecs[i].value) w++;
            check($sformatf("tab%0d_vals", i), 32'(w), 32'd0);
        end

        // cap at NUM_SAMP and discard of later pushes
        do_clear();
        push(8'h11, 100);
        push(8'h22, 50);
        wait_idle("cap_idle", 400);
        check("cap_len", 32'(got_v.size()), 32'd128);
        w = 0;
        foreach (got_v[k])
            if (got_v[k] !== ((k < 100) ? 8'h11 : 8'h22)) w++;
        check("cap_vals", 32'(w), 32'd0);
        check("cap_nsamp", n_samples, 32'd128);
        check("cap_trunc", 32'(truncated), 32'd1);
        push(8'h33, 4);
        wait_idle("cap_idle2", 50);
        check("cap_len2", 32'(got_v.size()), 32'd128);
        check("cap_nsamp2", n_samples, 32'd128);

        // overflow on a full FIFO, then clear
        do_clear();
        push(8'h01, 1000);
        for (int i = 0; i < DEPTH; i++) push(8'h02, 1);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_pre", 32'(overflow), 32'd0);
        push(8'h03, 1);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        do_clear();
        check("clr_strobe", 32'(bus.write_channel_wrStrobe), 32'd0);
        check("clr_nsamp", n_samples, 32'd0);
        check("clr_flags", {28'd0, fifo_full, busy, overflow, truncated},
              32'd0);

        // reset in the middle of an expansion
        push(8'h3C, 10);
        wait_words("rst_mid_wait", 4, 50);
        axi_reset = 1'b1;
        tick();
        check("rstm_wc", 32'(bus.write_channel), 32'd0);
        check("rstm_strobe", 32'(bus.write_channel_wrStrobe), 32'd0);
        check("rstm_nsamp", n_samples, 32'd0);
        check("rstm_flags", {28'd0, fifo_full, busy, overflow, truncated},
              32'd0);
        axi_reset = 1'b0;
        tick();
        flush_log();
        push(8'h01, 2);
        wait_idle("rstm_idle", 50);
        check("rstm_len", 32'(got_v.size()), 32'd2);
        check("rstm_nsamp2", n_samples, 32'd2);

        // push into full FIFO on the same cycle as a pop
        do_clear();
        model_reset();
        push(8'h01, 40);
        model_push(8'h01, 40);
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(8'h10 + i), 1);
            model_push(8'(8'h10 + i), 1);
        end
        check("pp_full", 32'(fifo_full), 32'd1);
        wait_words("pp_wait", 39, 100);
        push(8'h7E, 1);
        model_push(8'h7E, 1);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_full2", 32'(fifo_full), 32'd1);
        wait_idle("pp_idle", 200);
        cmp_stream("pp");
        check("pp_ovf2", 32'(overflow), 32'd0);

        // randomized entries against the reference model
        for (int r = 0; r < 3; r++) begin
            do_clear();
            model_reset();
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                w = 0;
                while (fifo_full && w < 200) begin
                    tick();
                    w++;
                end
                rv = 8'($urandom);
                rc = $urandom_range(0, maxc[r]);
                push(rv, rc);
                model_push(rv, rc);
            end
            wait_idle($sformatf("r%0d_idle", r), 2000);
            cmp_stream($sformatf("r%0d", r));
            check($sformatf("r%0d_nsamp", r), n_samples, 32'(m_total));
            check($sformatf("r%0d_trunc", r), 32'(truncated),
                  32'(m_trunc));
            check($sformatf("r%0d_ovf", r), 32'(overflow), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
